// File: rtl/booth_mul_seq.sv
`timescale 1ns/1ps
// booth_mul_seq: iterative radix-4 Booth multiplier, one digit per clock, valid/ready handshakes
//
// Parameters
//   WIDTH      operand width (even, >= 4); product is 2*WIDTH bits
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   a, b, is_signed are valid
//   in_ready   block can accept an operation (IDLE)
//   a          multiplicand
//   b          multiplier, Booth-recoded
//   is_signed  1: two's-complement operands, 0: unsigned
//   out_valid  product is valid (DONE)
//   out_ready  consumer accepts product
//   product    exact a*b in the mode latched at accept
//   busy       high in BUSY or DONE
module booth_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);
    localparam int E  = WIDTH + 2;
    localparam int N  = E / 2;
    localparam int AW = 2 * E;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [AW-1:0]      mcand_q, mcand_d;
    logic [E-1:0]       mult_q, mult_d;
    logic               prev_q, prev_d;
    logic [2*WIDTH-1:0] product_q, product_d;

    logic               last;
    logic [2:0]         digit;
    logic [AW-1:0]      term;
    logic               sa, sb;

    assign last  = cnt_q == CW'(N - 1);
    assign digit = {mult_q[1:0], prev_q};
    assign sa    = is_signed & a[WIDTH-1];
    assign sb    = is_signed & b[WIDTH-1];

    // mcand_q carries the 4^k weight by shifting left two places per digit
    assign term = (digit == 3'b001 || digit == 3'b010) ? mcand_q :
                  (digit == 3'b011)                    ? mcand_q << 1 :
                  (digit == 3'b100)                    ? -(mcand_q << 1) :
                  (digit == 3'b101 || digit == 3'b110) ? -mcand_q : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mult_q    <= '0;
            prev_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mult_q    <= mult_d;
            prev_q    <= prev_d;
            product_q <= product_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = in_valid ? BUSY : IDLE;
            BUSY:    state_d = last ? DONE : BUSY;
            DONE:    state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        busy      = state_q != IDLE;
        product   = product_q;
    end

    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mult_d    = mult_q;
        prev_d    = prev_q;
        product_d = product_q;
        if (state_q == IDLE && in_valid) begin
            // extension bits are the MSB only in signed mode, so unsigned MSB=1 stays positive
            cnt_d   = '0;
            acc_d   = '0;
            mcand_d = {{(AW-WIDTH){sa}}, a};
            mult_d  = {{2{sb}}, b};
            prev_d  = 1'b0;
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q + 1'b1;
            acc_d   = acc_q + term;
            mcand_d = mcand_q << 2;
            mult_d  = {2'b00, mult_q[E-1:2]};
            prev_d  = mult_q[1];
            if (last)
                product_d = acc_d[2*WIDTH-1:0];
        end
    end
endmodule

// File: tb/tb_booth_mul_seq.sv
`timescale 1ns/1ps
// tb_booth_mul_seq: directed self-checking bench for booth_mul_seq at WIDTH=16
module tb_booth_mul_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        is_signed = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] product;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    booth_mul_seq #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int g = 0;
        while (!in_ready && g < 50) begin tick(); g++; end
        check({tag, " ready"}, in_ready, 1);
    endtask

    task automatic accept(input logic [15:0] av, input logic [15:0] bv, input logic sv);
        a = av; b = bv; is_signed = sv; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; a = ~av; b = ~bv; is_signed = ~sv;
    endtask

    task automatic do_op(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input logic [31:0] ex, input string tag);
        int lat = 0;
        logic rdy_seen = 1'b0;
        wait_ready(tag);
        accept(av, bv, sv);
        while (!out_valid && lat < 40) begin
            rdy_seen |= in_ready;
            tick();
            lat++;
        end
        check({tag, " latency"}, lat, 9);
        check({tag, " product"}, product, ex);
        check({tag, " in_ready low while busy"}, rdy_seen, 0);
        check({tag, " busy"}, busy, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, " out_valid cleared"}, out_valid, 0);
        check({tag, " idle"}, in_ready, 1);
        check({tag, " product held"}, product, ex);
    endtask

    initial begin
        int t[3];
        int cyc;
        int n_acc;
        int g;
        logic seen;

        #12;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset product", product, 0);
        rst_n = 1'b1;
        tick();

        do_op(16'hFFFD, 16'h0005, 1'b1, 32'hFFFFFFF1, "signed -3*5");
        do_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, "unsigned ffff*ffff");
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, "signed -1*-1");
        do_op(16'h8000, 16'h8000, 1'b1, 32'h40000000, "signed min*min");
        do_op(16'h8000, 16'h7FFF, 1'b1, 32'hC0008000, "signed min*max");
        do_op(16'h8000, 16'h7FFF, 1'b0, 32'h3FFF8000, "unsigned 8000*7fff");
        do_op(16'h0000, 16'h1234, 1'b1, 32'h00000000, "zero a");
        do_op(16'h1234, 16'h5678, 1'b0, 32'h06260060, "unsigned 1234*5678");

        // backpressure: result and flags must hold while out_ready stays low
        wait_ready("bp");
        accept(16'h1234, 16'h5678, 1'b0);
        g = 0;
        while (!out_valid && g < 40) begin tick(); g++; end
        check("bp out_valid rose", out_valid, 1);
        for (int i = 0; i < 6; i++) begin
            a = 16'(i + 3); b = 16'h7; in_valid = 1'b1;
            tick();
            check("bp out_valid stable", out_valid, 1);
            check("bp product stable", product, 32'h06260060);
            check("bp in_ready low", in_ready, 0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp released idle", in_ready, 1);
        check("bp released out_valid", out_valid, 0);
        check("bp released product", product, 32'h06260060);

        // back-to-back initiation interval with in_valid and out_ready held high
        a = 16'd3; b = 16'd4; is_signed = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        cyc = 0; n_acc = 0;
        while (n_acc < 3 && cyc < 100) begin
            if (in_ready) begin t[n_acc] = cyc; n_acc++; end
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("ii accepts", n_acc, 3);
        check("ii first", t[1] - t[0], 11);
        check("ii second", t[2] - t[1], 11);
        g = 0;
        while (!in_ready && g < 40) begin tick(); g++; end
        check("ii drained", in_ready, 1);
        check("ii product", product, 32'd12);
        out_ready = 1'b0;

        // asynchronous reset in the middle of an operation
        wait_ready("rst");
        accept(16'd100, 16'd100, 1'b0);
        repeat (4) tick();
        rst_n = 1'b0;
        #2;
        check("midrst in_ready", in_ready, 1);
        check("midrst out_valid", out_valid, 0);
        check("midrst busy", busy, 0);
        check("midrst product", product, 0);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            seen |= out_valid;
            tick();
        end
        check("midrst no out_valid", seen, 0);
        do_op(16'd7, 16'hFFF7, 1'b1, 32'hFFFFFFC1, "signed 7*-9");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
